// File: rtl/iter_alu_unit.sv
// Iterative ALU execution stage: latches register-file operands on command
// acceptance, runs one op (shift-add MUL over DATA_WIDTH cycles), writes back via BusC.
module iter_alu_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic [DATA_WIDTH-1:0] bus_a,
    input  logic [DATA_WIDTH-1:0] bus_b,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] hi_data,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_n
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_e;

    typedef struct packed {
        op_e                   op;
        logic [ADDR_WIDTH-1:0] dest;
        logic [DW-1:0]         a;
    } cmd_t;

    state_e        state, state_nxt;
    cmd_t          cmd;
    logic [2*DW-1:0] acc, acc_nxt;
    logic [CW-1:0] cnt;
    logic [DW:0]   psum;
    logic [DW-1:0] opb;
    logic          is_mul, last_iter;

    logic [DW-1:0] res, res_hi;
    logic          res_c, res_z, res_n;

    // Operand B lives in the low accumulator half; for MUL it doubles as the multiplier.
    assign opb       = acc[DW-1:0];
    assign is_mul    = (cmd.op == OP_MUL);
    assign last_iter = (cnt == CW'(1));

    // One shift-add step: add multiplicand into upper half, shift right with carry into MSB.
    always_comb begin
        psum    = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, cmd.a} : {(DW+1){1'b0}});
        acc_nxt = {psum, acc[DW-1:1]};
    end

    always_comb begin
        res    = '0;
        res_hi = '0;
        res_c  = 1'b0;
        case (cmd.op)
            OP_ADD: {res_c, res} = {1'b0, cmd.a} + {1'b0, opb};
            OP_SUB: begin
                res   = cmd.a - opb;
                res_c = (cmd.a >= opb);
            end
            OP_AND: res = cmd.a & opb;
            OP_OR:  res = cmd.a | opb;
            OP_XOR: res = cmd.a ^ opb;
            OP_SHL: begin
                res   = {cmd.a[DW-2:0], 1'b0};
                res_c = cmd.a[DW-1];
            end
            OP_MUL: begin
                res    = acc_nxt[DW-1:0];
                res_hi = acc_nxt[2*DW-1:DW];
                res_c  = |acc_nxt[2*DW-1:DW];
            end
            default: res = opb;
        endcase
        res_z = is_mul ? (acc_nxt == '0) : (res == '0);
        res_n = is_mul ? acc_nxt[2*DW-1] : res[DW-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXEC;
            EXEC:    if (!is_mul || last_iter) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        wr_en = (state == WRITE);
        done  = (state == WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cmd.op   <= op_e'(op);
                    cmd.dest <= dest;
                    cmd.a    <= bus_a;
                    acc      <= {{DW{1'b0}}, bus_b};
                    cnt      <= CW'(DATA_WIDTH);
                end
                EXEC: if (is_mul) begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Write-back data and status update only on the edge entering WRITE, so an abort leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr  <= '0;
            w_data  <= '0;
            hi_data <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
        end else if (state == EXEC && state_nxt == WRITE) begin
            w_addr  <= cmd.dest;
            w_data  <= res;
            hi_data <= res_hi;
            flag_z  <= res_z;
            flag_c  <= res_c;
            flag_n  <= res_n;
        end
    end

endmodule

// File: doc/iter_alu_unit.md
# iter_alu_unit

Execution stage sitting directly downstream of the 8-entry register file: it consumes the Bus A / Bus B read data, performs one ALU operation per command, and drives the register-file write port (BusC write enable, address, data) with the result. Single-cycle logic and arithmetic ops complete in 3 cycles. Unsigned multiply is iterative shift-add, one bit per cycle. Operands are latched at command acceptance, so write-back never races the operand reads.

## Interface
- DATA_WIDTH, 8, operand/result width; must match the register file.
- ADDR_WIDTH, 3, register-file address width.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; accepted only in IDLE
- op  in  3  operation code, sampled with start
- dest  in  ADDR_WIDTH  write-back register index, sampled with start
- bus_a  in  DATA_WIDTH  operand A (register file Bus A)
- bus_b  in  DATA_WIDTH  operand B (register file Bus B)
- busy  out  1  high in EXEC and WRITE
- done  out  1  one-cycle pulse, coincident with wr_en
- wr_en  out  1  register-file write enable (BusC)
- w_addr  out  ADDR_WIDTH  register-file write address
- w_data  out  DATA_WIDTH  register-file write data (low byte of result)
- hi_data  out  DATA_WIDTH  high byte of last MUL product; 0 for other ops
- flag_z, flag_c, flag_n  out  1 each  status of last completed op

## Operation
- Op codes:
  - 000 ADD: A+B; C = carry out.
  - 001 SUB: A−B mod 2^W; C = 1 when A ≥ B (no borrow).
  - 010 AND, 011 OR, 100 XOR: C = 0.
  - 101 SHL: A<<1; C = A[W−1].
  - 110 MUL: unsigned A×B, 2W-bit product; low byte to w_data, high byte to hi_data; C = (hi ≠ 0).
  - 111 PASS: result = B; C = 0.
- Flag rules:
  - N = result bit W−1. For MUL, N = product bit 2W−1.
  - Z = (result == 0). For MUL, Z is evaluated on the full 2W-bit product.
- FSM states and transitions:
  - IDLE: if start, latch op, dest, bus_a and bus_b, then go to EXEC. MUL also clears the accumulator and loads iteration count = DATA_WIDTH.
  - EXEC, non-MUL: compute in one cycle, then go to WRITE.
  - EXEC, MUL: each cycle, if multiplier LSB = 1 add the multiplicand into the upper accumulator half, then shift the accumulator right by 1 with the carry entering the MSB. Decrement the count; go to WRITE when the count reaches 0.
  - WRITE: assert wr_en = 1 and done = 1 for exactly one cycle, with w_addr = latched dest and w_data = result. Always returns to IDLE.
- Flags and hi_data are registered on the edge entering WRITE and hold until the next op's WRITE. hi_data is cleared to 0 by non-MUL ops.
- start outside IDLE, including during the WRITE cycle, is ignored. There is no queueing.
- Outside WRITE, wr_en = 0 and done = 0. w_addr and w_data hold their last values (don't-care to the register file).

## Timing
- Reset (async assert, synchronous release): state = IDLE. busy, done, wr_en, w_addr, w_data, hi_data and all flags = 0. The accumulator and count are cleared.
- Reset mid-operation aborts the op: no write is issued and no flag update occurs.
- Latency, counted from the cycle in which start is sampled high (cycle 0):
  - Non-MUL: EXEC in cycle 1, WRITE (wr_en = 1) in cycle 2.
  - MUL: EXEC in cycles 1..DATA_WIDTH, WRITE in cycle DATA_WIDTH+1 (9 for W = 8).
- Maximum issue rate: one command every 3 cycles (non-MUL) or every DATA_WIDTH+2 cycles (MUL). The earliest next start is the cycle after WRITE.
- The register file captures w_data on the clk edge that ends the WRITE cycle. Writing the dest that supplied an operand is legal because operands are already latched.
- busy rises in the cycle after start and falls in the cycle after WRITE.

## Test plan
- ADD, A=200, B=100, dest=3 → cycle 2: wr_en=1, w_addr=3, w_data=44, C=1, Z=0, N=0, done pulses once.
- SUB, A=5, B=5 → w_data=0, Z=1, C=1, N=0. Then SUB A=3, B=5 → w_data=254, C=0, N=1.
- MUL, A=255, B=255 → wr_en exactly at cycle 9, w_data=0x01, hi_data=0xFE, C=1, Z=0, N=1. Then AND, A=0xF0, B=0x0F → w_data=0, hi_data=0, Z=1.
- start held high continuously for 20 cycles with op=ADD → exactly one write every 3 cycles. start pulses during EXEC or WRITE produce no extra writes.
- rst asserted asynchronously in cycle 4 of a MUL → all outputs 0 immediately, no wr_en pulse. After release, SHL A=0x81 → w_data=0x02, C=1, N=0.
- PASS, B=0x80, dest=7 → w_data=0x80, w_addr=7, N=1. Flags remain stable through the following IDLE cycles.
